// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// The optional watchdog is enabled with the RESET_SEQ_WDT_EN define.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } seq_state_e;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_seq_wdt.sv
// Watchdog for the reset sequencer: counts only while every stage is released.
// Instantiated by reset_sequencer only when RESET_SEQ_WDT_EN is defined.
module reset_seq_wdt #(
    parameter int unsigned WDT_CYCLES = 65536
) (
    input  logic clk,
    input  logic rstn,
    input  logic done_i,
    input  logic kick_i,
    output logic expire_o
);

    localparam int unsigned W = $clog2(WDT_CYCLES);
    localparam logic [W-1:0] LAST = W'(WDT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (!done_i || kick_i) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A kick in the terminal cycle suppresses the expiry.
    assign expire_o = done_i && !kick_i && (cnt_q == LAST);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all stages, then release them in index order with a fixed gap.
// Define RESET_SEQ_WDT_EN to add a watchdog that can request a re-sequence.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 8,
    parameter int unsigned WDT_CYCLES  = 65536
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sw_rst_req,
    input  logic                  wdt_kick,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  all_ready,
    output logic                  seq_busy,
    output logic [1:0]            rst_cause
);

    localparam int unsigned CNT_MAX = max_u(HOLD_CYCLES, GAP_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IDX_W   = $clog2(NUM_STAGES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    seq_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_STAGES-1:0] stage_q;
    logic                  ready_q;
    logic                  busy_q;
    logic [1:0]            cause_q;
    logic                  wdt_req;
    logic                  in_done;

    assign in_done = (state_q == DONE);

`ifdef RESET_SEQ_WDT_EN
    reset_seq_wdt #(
        .WDT_CYCLES(WDT_CYCLES)
    ) u_wdt (
        .clk     (clk),
        .rstn    (rstn),
        .done_i  (in_done),
        .kick_i  (wdt_kick),
        .expire_o(wdt_req)
    );
`else
    logic unused_wdt;
    assign wdt_req    = 1'b0;
    assign unused_wdt = wdt_kick ^ in_done ^ (WDT_CYCLES == 0);
`endif

    // One counter serves both hold and gap timing; it clears on every state change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= CAUSE_POR;
        end else if (sw_rst_req || wdt_req) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= wdt_req ? CAUSE_WDT : CAUSE_SW;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= IDX_W'(1);
                        stage_q <= NUM_STAGES'(1);
                        if (NUM_STAGES == 1) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 1'b1;
                        stage_q <= stage_q | (NUM_STAGES'(1) << idx_q);
                        if (idx_q == IDX_LAST) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    cnt_q <= '0;
                end
                default: begin
                    state_q <= HOLD;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    stage_q <= '0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign stage_rst_n = stage_q;
    assign all_ready   = ready_q;
    assign seq_busy    = busy_q;
    assign rst_cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer against an elapsed-edge reference model.
// Watchdog scenarios are compiled in when RESET_SEQ_WDT_EN is defined.
module tb_reset_sequencer;

    localparam int N      = 4;
    localparam int H      = 16;
    localparam int G      = 8;
    localparam int WDT    = 100;
    localparam int T_DONE = H + (N - 1) * G;

    logic         clk;
    logic         rstn;
    logic         sw_rst_req;
    logic         wdt_kick;
    logic [N-1:0] stage_rst_n;
    logic         all_ready;
    logic         seq_busy;
    logic [1:0]   rst_cause;

    logic         s1_stage;
    logic         s1_ready;
    logic         s1_busy;
    logic [1:0]   s1_cause;
    logic         zero_in;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .NUM_STAGES(N), .HOLD_CYCLES(H), .GAP_CYCLES(G), .WDT_CYCLES(WDT)
    ) dut (
        .clk(clk), .rstn(rstn), .sw_rst_req(sw_rst_req), .wdt_kick(wdt_kick),
        .stage_rst_n(stage_rst_n), .all_ready(all_ready), .seq_busy(seq_busy),
        .rst_cause(rst_cause)
    );

    reset_sequencer #(
        .NUM_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .WDT_CYCLES(65536)
    ) dut1 (
        .clk(clk), .rstn(rstn), .sw_rst_req(zero_in), .wdt_kick(zero_in),
        .stage_rst_n(s1_stage), .all_ready(s1_ready), .seq_busy(s1_busy),
        .rst_cause(s1_cause)
    );

    assign zero_in = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [N+3:0] obs = {stage_rst_n, all_ready, seq_busy, rst_cause};
    localparam logic [N+3:0] RESET_VEC = {{N{1'b0}}, 1'b0, 1'b1, 2'b00};

    // Reference: m_n = edges since the current sequence started.
    int         m_n;
    int         m_w;
    logic [1:0] m_cause;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_n     = 0;
            m_w     = 0;
            m_cause = 2'b00;
        end else begin
            bit done_b;
            bit expire_b;
            done_b   = (m_n >= T_DONE);
            expire_b = 1'b0;
`ifdef RESET_SEQ_WDT_EN
            expire_b = done_b && !wdt_kick && (m_w == WDT - 1);
`endif
            if (expire_b || sw_rst_req) begin
                m_n     = 0;
                m_w     = 0;
                m_cause = expire_b ? 2'b10 : 2'b01;
            end else begin
                if (m_n < 100000) m_n++;
                m_w = (done_b && !wdt_kick) ? m_w + 1 : 0;
            end
        end
    end

    function automatic logic [N+3:0] exp_vec();
        logic [N-1:0] st;
        for (int k = 0; k < N; k++) st[k] = (m_n >= H + k * G);
        return {st, (m_n >= T_DONE), (m_n < T_DONE), m_cause};
    endfunction

    task automatic do_reset();
        rstn       = 1'b0;
        sw_rst_req = 1'b0;
        wdt_kick   = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        sw_rst_req = 1'b0;
        wdt_kick   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_vals got=%h exp=%h", obs, RESET_VEC);
        end
        checks++;
        if ({s1_stage, s1_ready, s1_busy, s1_cause} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_vals_single got=%b exp=00100", {s1_stage, s1_ready, s1_busy, s1_cause});
        end
        rstn = 1'b1;
    endtask

    // Caller leaves rstn just released at a falling edge; loop index = edge number.
    task automatic test_power_on();
        for (int i = 1; i <= 59; i++) begin
            automatic logic [3:0] want;
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL power_on edge=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            if (i == 16 || i == 24 || i == 32 || i == 40) begin
                want = 4'b1111 >> ((40 - i) / 8);
                checks++;
                if (stage_rst_n !== want) begin
                    errors++;
                    $display("FAIL stage_step edge=%0d got=%b exp=%b", i, stage_rst_n, want);
                end
            end
            if (i == 39 || i == 40) begin
                checks++;
                if (all_ready !== (i == 40)) begin
                    errors++;
                    $display("FAIL all_ready_edge edge=%0d got=%b exp=%b", i, all_ready, (i == 40));
                end
            end
            if (i == 1) begin
                checks++;
                if ({s1_stage, s1_ready, s1_busy} !== 3'b110) begin
                    errors++;
                    $display("FAIL single_stage_edge1 got=%b exp=110", {s1_stage, s1_ready, s1_busy});
                end
            end
        end
        checks++;
        if (rst_cause !== 2'b00) begin
            errors++;
            $display("FAIL por_cause got=%b exp=00", rst_cause);
        end
    endtask

    task automatic test_sw_request();
        for (int i = 60; i <= 100; i++) begin
            sw_rst_req = (i == 60);
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL sw_req edge=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            if (i == 60 || i == 75 || i == 76) begin
                checks++;
                if ({stage_rst_n, rst_cause} !== {3'b000, (i == 76), 2'b01}) begin
                    errors++;
                    $display("FAIL sw_req_edge edge=%0d got=%b exp=%b", i, {stage_rst_n, rst_cause}, {3'b000, (i == 76), 2'b01});
                end
            end
        end
        sw_rst_req = 1'b0;
    endtask

    task automatic test_restart_in_hold();
        do_reset();
        for (int i = 1; i <= 60; i++) begin
            sw_rst_req = (i == 28 || i == 35);
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL restart edge=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            if (i == 50 || i == 51) begin
                checks++;
                if (stage_rst_n[0] !== (i == 51)) begin
                    errors++;
                    $display("FAIL restart_stage0 edge=%0d got=%b exp=%b", i, stage_rst_n[0], (i == 51));
                end
            end
        end
        sw_rst_req = 1'b0;
    endtask

    task automatic test_rstn_mid_release();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL pre_abort edge=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL async_abort got=%h exp=%h", obs, RESET_VEC);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL post_abort edge=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            if (i == 15 || i == 16) begin
                checks++;
                if (stage_rst_n !== {3'b000, (i == 16)}) begin
                    errors++;
                    $display("FAIL post_abort_stage0 edge=%0d got=%b exp=%b", i, stage_rst_n, {3'b000, (i == 16)});
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 1; i <= 800; i++) begin
            sw_rst_req = ($urandom_range(0, 149) == 0);
            wdt_kick   = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        sw_rst_req = 1'b0;
        wdt_kick   = 1'b0;
    endtask

`ifdef RESET_SEQ_WDT_EN
    task automatic test_watchdog();
        do_reset();
        for (int i = 1; i <= T_DONE + WDT + 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL wdt_expire edge=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            if (i == T_DONE + WDT - 1 || i == T_DONE + WDT) begin
                checks++;
                if ({all_ready, rst_cause} !== ((i == T_DONE + WDT) ? 3'b010 : 3'b100)) begin
                    errors++;
                    $display("FAIL wdt_expire_edge edge=%0d got=%b", i, {all_ready, rst_cause});
                end
            end
        end
        do_reset();
        for (int i = 1; i <= 400; i++) begin
            wdt_kick = (i % 50 == 0);
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL wdt_kicked edge=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        wdt_kick = 1'b0;
        checks++;
        if ({all_ready, rst_cause} !== 3'b100) begin
            errors++;
            $display("FAIL wdt_kicked_final got=%b exp=100", {all_ready, rst_cause});
        end
    endtask
`else
    task automatic test_watchdog();
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            wdt_kick = $urandom_range(0, 1) == 1;
            @(negedge clk);
            checks++;
            if (obs !== exp_vec() || rst_cause === 2'b10) begin
                errors++;
                $display("FAIL no_wdt edge=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        wdt_kick = 1'b0;
    endtask
`endif

    initial begin
        rstn       = 1'b0;
        sw_rst_req = 1'b0;
        wdt_kick   = 1'b0;
        test_reset();
        test_power_on();
        test_sw_request();
        test_restart_in_hold();
        test_rstn_mid_release();
        test_watchdog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Drives the staged reset outputs for downstream blocks, starting from the already-conditioned system reset. After `rstn` releases, it holds every stage in reset for a minimum time, then releases the stages one at a time in index order with a fixed gap between them. Software can request a full re-sequence at any time, and an optional watchdog can request one too. The block runs on the filtered reset and system clock and feeds the per-block `*_rstn` inputs.

## Interface
- `NUM_STAGES`, default 4: number of staged reset outputs; legal range 1..16.
- `HOLD_CYCLES`, default 16: number of cycles all stages stay asserted before stage 0 releases; must be ≥1.
- `GAP_CYCLES`, default 8: number of cycles between consecutive stage releases; must be ≥1.
- `WDT_CYCLES`, default 65536: watchdog timeout in cycles; used only when `RESET_SEQ_WDT_EN` is defined; must be ≥2.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `sw_rst_req` in 1: synchronous one-cycle pulse that requests a full re-sequence.
- `wdt_kick` in 1: synchronous watchdog service pulse; ignored when the watchdog is compiled out.
- `stage_rst_n` out NUM_STAGES: per-stage active-low resets; registered.
- `all_ready` out 1: high once every stage is released; registered.
- `seq_busy` out 1: high while sequencing; always equal to `!all_ready`; registered.
- `rst_cause` out 2: cause of the last sequence; 00 power-on, 01 software, 10 watchdog; registered.

## Operation
- States:
  - HOLD: all stages asserted; hold counter running.
  - RELEASE: stage index `idx` and gap counter running.
  - DONE: all stages released.
- Reset values while `rstn` is low:
  - state HOLD, counters 0, `idx` 0.
  - `stage_rst_n` all 0, `all_ready` 0, `seq_busy` 1, `rst_cause` 00.
- HOLD → RELEASE: on the edge where the hold counter equals `HOLD_CYCLES-1`, set `stage_rst_n[0]` to 1, set `idx` to 1 and clear the gap counter.
  - If `NUM_STAGES`==1, go straight to DONE on that edge and set `all_ready` to 1.
- In RELEASE: on the edge where the gap counter equals `GAP_CYCLES-1`, set `stage_rst_n[idx]` to 1 and increment `idx`.
  - If `idx` was `NUM_STAGES-1`, go to DONE on the same edge and set `all_ready` to 1.
- Release order is strictly increasing by index. A released stage is never reasserted except by a request or by `rstn`.
- A request is `sw_rst_req`, or watchdog expiry when the watchdog is compiled in. A request in any state does the following on the next edge:
  - all `stage_rst_n` go to 0; `all_ready` goes to 0.
  - state becomes HOLD, counters and `idx` clear.
  - `rst_cause` updates.
- A request received while already in HOLD restarts the hold count from 0.
- If software and watchdog requests arrive in the same cycle, `rst_cause` records 10 (watchdog wins).
- `rst_cause` holds its value until the next request or `rstn`.
- Counter width is `$clog2(max(HOLD_CYCLES,GAP_CYCLES))`. Counters never wrap within a state because they clear on every state change.
- Asserting `rstn` mid-sequence forces the reset values immediately and asynchronously.

## Timing
- Edge 1 is the first rising `clk` edge at which `rstn` is sampled high.
- Stage k goes high on edge `HOLD_CYCLES + k*GAP_CYCLES`.
- `all_ready` goes high on edge `HOLD_CYCLES + (NUM_STAGES-1)*GAP_CYCLES`.
- A request sampled on edge t makes all stages 0 after edge t, and the next sequence counts from edge t+1.
- Latency from request to outputs asserted: 1 cycle.

## Configuration
- `RESET_SEQ_WDT_EN` defined: the watchdog counter runs only in DONE; it holds at 0 in every other state.
  - `wdt_kick` clears the counter.
  - When the counter reaches `WDT_CYCLES-1` with no kick in that cycle, it issues a one-cycle request that is acted on at the next edge.
  - A kick in the expiry cycle wins, and no request is issued.
- `RESET_SEQ_WDT_EN` undefined: no watchdog logic; `wdt_kick` is unused; `rst_cause` can never be 10.

## Structure
- Package `reset_seq_pkg` contains:
  - state enum (HOLD, RELEASE, DONE).
  - cause constants `CAUSE_POR`=2'b00, `CAUSE_SW`=2'b01, `CAUSE_WDT`=2'b10.
- Sub-module `reset_seq_wdt` contains the watchdog counter and expiry pulse. It is instantiated only under `RESET_SEQ_WDT_EN`.

## Test plan
- Defaults; release `rstn` → `stage_rst_n` steps 0000→0001 at edge 16, 0011 at 24, 0111 at 32, 1111 at 40; `all_ready` rises at edge 40; `rst_cause`=00.
- `sw_rst_req` pulse at edge 60 → all stages 0 after edge 60; stage 0 high at edge 76; `rst_cause`=01.
- `sw_rst_req` during RELEASE (edge 28), then again in HOLD (edge 35) → hold count restarts; stage 0 high at edge 51.
- `NUM_STAGES`=1, `HOLD_CYCLES`=1 → stage 0 and `all_ready` high on edge 1.
- Watchdog on, `WDT_CYCLES`=100, no kicks → request 100 cycles after DONE; `rst_cause`=10. Kick every 50 cycles → no re-sequence.
- `rstn` pulsed low mid-RELEASE → outputs return to reset values immediately; sequence restarts from edge 1.
